// File: rtl/kmeans_ctrl_pkg.sv
// Shared types for the k-means iteration controller: FSM state encoding, error codes
// and small state-classification helpers.
package kmeans_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_INIT_START  = 4'd1,
        ST_INIT_WAIT   = 4'd2,
        ST_MAP_START   = 4'd3,
        ST_MAP_WAIT    = 4'd4,
        ST_MERGE_START = 4'd5,
        ST_MERGE_WAIT  = 4'd6,
        ST_CHECK       = 4'd7,
        ST_FINISH      = 4'd8,
        ST_ERROR       = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_WCNT    = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_RSVD    = 2'b11
    } err_code_t;

    function automatic logic is_start_state(state_t s);
        return s inside {ST_INIT_START, ST_MAP_START, ST_MERGE_START};
    endfunction

    function automatic logic is_wait_state(state_t s);
        return s inside {ST_INIT_WAIT, ST_MAP_WAIT, ST_MERGE_WAIT};
    endfunction

    // Only the three resting states accept a new run.
    function automatic logic is_busy_state(state_t s);
        return !(s inside {ST_IDLE, ST_FINISH, ST_ERROR});
    endfunction

endpackage

// File: rtl/kmeans_iter_ctrl_if.sv
// Handshake bundle between the iteration controller (master) and the merge/mapper
// datapath plus host (slave).
interface kmeans_iter_ctrl_if #(
    parameter int ITER_BITS = 8
);

    logic                 i_go;
    logic [ITER_BITS-1:0] i_max_iter;
    logic                 i_converged;
    logic                 o_map_start;
    logic                 i_map_done;
    logic                 o_merge_init;
    logic                 o_merge_start;
    logic                 i_merge_done;
    logic                 i_centre_we;
    logic                 o_busy;
    logic                 o_done;
    logic [ITER_BITS-1:0] o_iter;
    logic                 o_error;
    logic [1:0]           o_err_code;

    modport master (
        input  i_go,
        input  i_max_iter,
        input  i_converged,
        input  i_map_done,
        input  i_merge_done,
        input  i_centre_we,
        output o_map_start,
        output o_merge_init,
        output o_merge_start,
        output o_busy,
        output o_done,
        output o_iter,
        output o_error,
        output o_err_code
    );

    modport slave (
        output i_go,
        output i_max_iter,
        output i_converged,
        output i_map_done,
        output i_merge_done,
        output i_centre_we,
        input  o_map_start,
        input  o_merge_init,
        input  o_merge_start,
        input  o_busy,
        input  o_done,
        input  o_iter,
        input  o_error,
        input  o_err_code
    );

endinterface

// File: rtl/phase_watchdog.sv
// Cycle watchdog for one wait phase: cleared before the phase, counts while enabled and
// flags expiry on the TIMEOUT-th enabled cycle.
module phase_watchdog #(
    parameter int TIMEOUT = 65535,
    parameter int TO_BITS = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // Holding count N-1 means the current enabled cycle is the N-th one.
    localparam logic [TO_BITS-1:0] LAST = TO_BITS'(TIMEOUT - 1);

    logic [TO_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/kmeans_iter_ctrl.sv
// k-means run sequencer: init merge pass, then map + centre-update passes until the
// iteration limit or convergence, with per-pass write audit and phase watchdog.
module kmeans_iter_ctrl
    import kmeans_ctrl_pkg::*;
#(
    parameter int K         = 10,
    parameter int ADDR_BITS = 4,
    parameter int ITER_BITS = 8,
    parameter int TIMEOUT   = 65535,
    parameter int TO_BITS   = 16
) (
    input  logic               clock,
    input  logic               reset,
    kmeans_iter_ctrl_if.master bus
);

    localparam logic [ADDR_BITS-1:0] WCNT_TARGET = ADDR_BITS'(K);
    localparam logic [ADDR_BITS-1:0] WCNT_SAT    = ADDR_BITS'(K + 1);

    state_t               state_q, state_d;
    logic [ITER_BITS-1:0] max_iter_q, max_iter_d;
    logic [ITER_BITS-1:0] iter_q, iter_d, iter_inc;
    logic [ADDR_BITS-1:0] wcnt_q, wcnt_d, wcnt_final;
    err_code_t            err_q, err_d;
    logic                 wcnt_ok;
    logic                 wd_clear, wd_enable, wd_expired;

    logic map_start_q;
    logic merge_start_q;
    logic merge_init_q;
    logic busy_q;
    logic done_q;
    logic error_q;

    phase_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_BITS (TO_BITS)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    // Every *_WAIT is entered from its *_START, so clearing in START is clearing on entry.
    assign wd_clear  = is_start_state(state_q);
    assign wd_enable = is_wait_state(state_q);
    assign iter_inc  = iter_q + 1'b1;

    // A write strobe in the done cycle still belongs to the pass being audited.
    always_comb begin
        wcnt_final = wcnt_q;
        if (bus.i_centre_we && (wcnt_q != WCNT_SAT)) begin
            wcnt_final = wcnt_q + 1'b1;
        end
    end

    assign wcnt_ok = (wcnt_final == WCNT_TARGET);

    // NOTE: every variable gets a default at the top of the block, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        max_iter_d = max_iter_q;
        iter_d     = iter_q;
        err_d      = err_q;
        wcnt_d     = wcnt_q;

        if (is_start_state(state_q)) begin
            wcnt_d = '0;
        end else if (state_q inside {ST_INIT_WAIT, ST_MERGE_WAIT}) begin
            wcnt_d = wcnt_final;
        end

        case (state_q)
            ST_IDLE, ST_FINISH, ST_ERROR: begin
                if (bus.i_go) begin
                    state_d    = ST_INIT_START;
                    max_iter_d = bus.i_max_iter;
                    iter_d     = '0;
                    err_d      = ERR_NONE;
                end
            end

            ST_INIT_START: state_d = ST_INIT_WAIT;

            ST_INIT_WAIT: begin
                if (bus.i_merge_done) begin
                    if (!wcnt_ok) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_WCNT;
                    end else if (max_iter_q == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_MAP_START;
                    end
                end else if (wd_expired) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end

            ST_MAP_START: state_d = ST_MAP_WAIT;

            ST_MAP_WAIT: begin
                if (bus.i_map_done) begin
                    state_d = ST_MERGE_START;
                end else if (wd_expired) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end

            ST_MERGE_START: state_d = ST_MERGE_WAIT;

            ST_MERGE_WAIT: begin
                if (bus.i_merge_done) begin
                    if (!wcnt_ok) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_WCNT;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else if (wd_expired) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end

            ST_CHECK: begin
                iter_d = iter_inc;
                if ((iter_inc == max_iter_q) || bus.i_converged) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_MAP_START;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: outputs are registered from the next state, so they change on the same edge
    // as the state register yet never glitch through a state decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            max_iter_q    <= '0;
            iter_q        <= '0;
            wcnt_q        <= '0;
            err_q         <= ERR_NONE;
            map_start_q   <= 1'b0;
            merge_start_q <= 1'b0;
            merge_init_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            max_iter_q    <= max_iter_d;
            iter_q        <= iter_d;
            wcnt_q        <= wcnt_d;
            err_q         <= err_d;
            map_start_q   <= (state_d == ST_MAP_START);
            merge_start_q <= (state_d inside {ST_INIT_START, ST_MERGE_START});
            merge_init_q  <= (state_d inside {ST_INIT_START, ST_INIT_WAIT});
            busy_q        <= is_busy_state(state_d);
            done_q        <= (state_d == ST_FINISH) && (state_q != ST_FINISH);
            error_q       <= (state_d == ST_ERROR);
        end
    end

    assign bus.o_map_start   = map_start_q;
    assign bus.o_merge_start = merge_start_q;
    assign bus.o_merge_init  = merge_init_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_iter        = iter_q;
    assign bus.o_error       = error_q;
    assign bus.o_err_code    = err_q;

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Self-checking bench for kmeans_iter_ctrl: scripted runs with randomized datapath timing,
// an expectation model driven by the run script, and a per-cycle compare process.
module tb_kmeans_iter_ctrl;

    localparam int K         = 10;
    localparam int ADDR_BITS = 4;
    localparam int ITER_BITS = 8;
    localparam int TIMEOUT   = 100;
    localparam int TO_BITS   = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    kmeans_iter_ctrl_if #(.ITER_BITS(ITER_BITS)) bus ();

    kmeans_iter_ctrl #(
        .K         (K),
        .ADDR_BITS (ADDR_BITS),
        .ITER_BITS (ITER_BITS),
        .TIMEOUT   (TIMEOUT),
        .TO_BITS   (TO_BITS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected output values for the current cycle, maintained by the run script.
    bit e_busy, e_minit, e_mstart, e_mapst, e_done, e_err;
    int e_iter, e_code;

    int map_starts, merge_starts, dones;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_exp(input bit busy, input bit minit, input bit mstart, input bit mapst,
                           input bit done, input int iter, input bit err, input int code);
        e_busy = busy; e_minit = minit; e_mstart = mstart; e_mapst = mapst;
        e_done = done; e_iter = iter; e_err = err; e_code = code;
    endtask

    always @(negedge clock) begin
        check("o_busy",        32'(bus.o_busy),        32'(e_busy));
        check("o_merge_init",  32'(bus.o_merge_init),  32'(e_minit));
        check("o_merge_start", 32'(bus.o_merge_start), 32'(e_mstart));
        check("o_map_start",   32'(bus.o_map_start),   32'(e_mapst));
        check("o_done",        32'(bus.o_done),        32'(e_done));
        check("o_iter",        32'(bus.o_iter),        32'(e_iter));
        check("o_error",       32'(bus.o_error),       32'(e_err));
        check("o_err_code",    32'(bus.o_err_code),    32'(e_code));
        if (bus.o_map_start === 1'b1)   map_starts++;
        if (bus.o_merge_start === 1'b1) merge_starts++;
        if (bus.o_done === 1'b1)        dones++;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        bus.i_go         = 1'b0;
        bus.i_max_iter   = '0;
        bus.i_converged  = 1'b0;
        bus.i_map_done   = 1'b0;
        bus.i_merge_done = 1'b0;
        bus.i_centre_we  = 1'b0;
    endtask

    task automatic idle(input int n);
        quiet();
        repeat (n) cyc();
    endtask

    // Random activity on inputs the controller must ignore in the current phase.
    task automatic junk(input bit map_ok, input bit merge_ok);
        bus.i_go         = ($urandom_range(0, 7) == 0);
        bus.i_max_iter   = ITER_BITS'($urandom);
        bus.i_converged  = 1'($urandom_range(0, 1));
        bus.i_map_done   = map_ok   ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.i_merge_done = merge_ok ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.i_centre_we  = 1'($urandom_range(0, 1));
    endtask

    function automatic void clr_counts();
        map_starts = 0; merge_starts = 0; dones = 0;
    endfunction

    // Entered just after the *_START edge. status: 0 count ok, 1 count wrong, 2 reset abort.
    task automatic merge_pass(input bit init, input int nwr, input int it,
                              input int abort_at, output int status);
        bit pat [0:63];
        int len, last_we, tmp_j;
        bit tmp;
        junk(1, 1);
        cyc();
        set_exp(1, init, 0, 0, 0, it, 0, 0);
        len     = nwr + 1 + $urandom_range(0, 3);
        last_we = (nwr > 0) ? $urandom_range(0, 1) : 0;
        for (int i = 0; i < 64; i++) pat[i] = 1'b0;
        for (int i = 0; i < nwr - last_we; i++) pat[i] = 1'b1;
        for (int i = len - 2; i > 0; i--) begin
            tmp_j = $urandom_range(0, i);
            tmp = pat[i]; pat[i] = pat[tmp_j]; pat[tmp_j] = tmp;
        end
        pat[len-1] = 1'(last_we);
        for (int c = 0; c < len; c++) begin
            if (abort_at != 0 && c == abort_at) begin
                reset = 1'b1;
                set_exp(0, 0, 0, 0, 0, 0, 0, 0);
                #1;
                check("rst_async_busy",  32'(bus.o_busy),  32'd0);
                check("rst_async_iter",  32'(bus.o_iter),  32'd0);
                check("rst_async_error", 32'(bus.o_error), 32'd0);
                quiet();
                cyc();
                cyc();
                reset = 1'b0;
                status = 2;
                return;
            end
            junk(1, 0);
            bus.i_centre_we  = pat[c];
            bus.i_merge_done = (c == len - 1);
            cyc();
        end
        status = (nwr == K) ? 0 : 1;
    endtask

    // Entered just after the MAP_START edge. hang: 0 normal, 1 never done, 2 done at timeout.
    task automatic map_pass(input int it, input int hang, output bit ok);
        int len;
        junk(1, 1);
        cyc();
        set_exp(1, 0, 0, 0, 0, it, 0, 0);
        len = (hang != 0) ? TIMEOUT : $urandom_range(1, 12);
        for (int c = 1; c <= len; c++) begin
            junk(0, 1);
            bus.i_map_done = (hang != 1) && (c == len);
            cyc();
        end
        ok = (hang != 1);
    endtask

    // One complete run from an accepted i_go. Pass 0 is the init pass, pass n the n-th update.
    task automatic run(input int m, input int conv_at, input int bad_pass, input int bad_n,
                       input int hang_iter, input int hang_mode, input int abort_pass);
        int it = 0;
        int st;
        bit ok;
        quiet();
        bus.i_go       = 1'b1;
        bus.i_max_iter = ITER_BITS'(m);
        cyc();
        set_exp(1, 1, 1, 0, 0, 0, 0, 0);
        merge_pass(1, (bad_pass == 0) ? bad_n : K, 0, 0, st);
        if (st == 1) begin
            quiet();
            set_exp(0, 0, 0, 0, 0, 0, 1, 1);
            idle(3);
            return;
        end
        if (m == 0) begin
            quiet();
            set_exp(0, 0, 0, 0, 1, 0, 0, 0);
            cyc();
            set_exp(0, 0, 0, 0, 0, 0, 0, 0);
            idle(2);
            return;
        end
        forever begin
            set_exp(1, 0, 0, 1, 0, it, 0, 0);
            map_pass(it, (it + 1 == hang_iter) ? hang_mode : 0, ok);
            if (!ok) begin
                quiet();
                set_exp(0, 0, 0, 0, 0, it, 1, 2);
                idle(3);
                return;
            end
            set_exp(1, 0, 1, 0, 0, it, 0, 0);
            merge_pass(0, (it + 1 == bad_pass) ? bad_n : K, it,
                       (it + 1 == abort_pass) ? 2 : 0, st);
            if (st == 2) return;
            if (st == 1) begin
                quiet();
                set_exp(0, 0, 0, 0, 0, it, 1, 1);
                idle(3);
                return;
            end
            set_exp(1, 0, 0, 0, 0, it, 0, 0);
            junk(1, 1);
            bus.i_converged = (it + 1 == conv_at);
            cyc();
            it++;
            if (it == m || it == conv_at) begin
                quiet();
                set_exp(0, 0, 0, 0, 1, it, 0, 0);
                cyc();
                set_exp(0, 0, 0, 0, 0, it, 0, 0);
                idle(2);
                return;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_guard: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int m, conv;
        quiet();
        set_exp(0, 0, 0, 0, 0, 0, 0, 0);
        clr_counts();
        repeat (3) cyc();
        reset = 1'b0;
        idle(2);

        // Plain three-iteration run.
        clr_counts();
        run(3, 0, -1, K, 0, 0, 0);
        check("s1_iter",         32'(bus.o_iter), 32'd3);
        check("s1_done_pulses",  32'(dones),        32'd1);
        check("s1_map_starts",   32'(map_starts),   32'd3);
        check("s1_merge_starts", 32'(merge_starts), 32'd4);

        // Early convergence at the first check.
        clr_counts();
        run(5, 1, -1, K, 0, 0, 0);
        check("s2_iter",       32'(bus.o_iter), 32'd1);
        check("s2_map_starts", 32'(map_starts), 32'd1);

        // Zero iterations: init pass only.
        clr_counts();
        run(0, 0, -1, K, 0, 0, 0);
        check("s3_iter",        32'(bus.o_iter), 32'd0);
        check("s3_map_starts",  32'(map_starts), 32'd0);
        check("s3_done_pulses", 32'(dones),      32'd1);

        // Short init pass, then a clean fresh run.
        run(2, 0, 0, K - 1, 0, 0, 0);
        check("s4_err_code", 32'(bus.o_err_code), 32'd1);
        check("s4_error",    32'(bus.o_error),    32'd1);
        run(2, 0, -1, K, 0, 0, 0);
        check("s4_recover_error", 32'(bus.o_error), 32'd0);
        check("s4_recover_iter",  32'(bus.o_iter),  32'd2);

        // Map phase timeout, then done landing on the timeout cycle.
        run(2, 0, -1, K, 1, 1, 0);
        check("s5_err_code", 32'(bus.o_err_code), 32'd2);
        check("s5_iter",     32'(bus.o_iter),     32'd0);
        run(1, 0, -1, K, 1, 2, 0);
        check("s5_race_error", 32'(bus.o_error), 32'd0);
        check("s5_race_iter",  32'(bus.o_iter),  32'd1);

        // Reset inside a centre-update pass, then a normal run.
        run(3, 0, -1, K, 0, 0, 1);
        check("s6_busy_after_reset", 32'(bus.o_busy), 32'd0);
        run(1, 0, -1, K, 0, 0, 0);
        check("s6_iter", 32'(bus.o_iter), 32'd1);

        // Over-count in the second update pass (saturation must not wrap back to K).
        run(3, 0, 2, 26, 0, 0, 0);
        check("s7_err_code", 32'(bus.o_err_code), 32'd1);
        check("s7_iter",     32'(bus.o_iter),     32'd1);
        run(2, 0, 0, K + 1, 0, 0, 0);
        check("s7_init_over", 32'(bus.o_err_code), 32'd1);

        // Randomized clean runs.
        for (int r = 0; r < 8; r++) begin
            m    = $urandom_range(1, 4);
            conv = $urandom_range(0, m);
            clr_counts();
            run(m, conv, -1, K, 0, 0, 0);
            check("rnd_done_pulses", 32'(dones), 32'd1);
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
